bnn_vote_accumulator: RTL and testbench
=======================================

BNN_VOTE_ACCUMULATOR -- requirements
Module: bnn_vote_accumulator

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4: number of layer-2 neuron outputs; each output is one class vote.
REQ-002 SHALL have parameter CNT_W, default 8: width of each class vote counter.
REQ-003 SHALL have parameter WINDOW, default 16: samples per decision, legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_votes carries a sample.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port in_votes, input, NUM_CLASSES: layer-2 neuron outputs; bit k is a vote for class k.
REQ-009 SHALL have port clear, input, 1: synchronous abort of the current window.
REQ-010 SHALL have port out_valid, output, 1: decision available.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the decision.
REQ-012 SHALL have port out_class, output, clog2(NUM_CLASSES): winning class index.
REQ-013 SHALL have port out_count, output, CNT_W: vote count of the winning class.
REQ-014 SHALL have port out_tie, output, 1: another class equals the winning count.

Function
REQ-015 SHALL implement states ACCUM, SCAN and RESULT; in_ready = (state==ACCUM), out_valid = (state==RESULT).
REQ-016 SHALL accept a sample on an edge where in_valid && in_ready, incrementing counter k for each set bit k and incrementing the sample counter.
REQ-017 SHALL saturate each class counter at 2^CNT_W-1; further votes leave it unchanged.
REQ-018 SHALL enter SCAN on the edge that accepts the WINDOW-th sample.
REQ-019 SHALL evaluate one class per cycle in SCAN, index 0 up to NUM_CLASSES-1, and enter RESULT with out_valid=1 exactly NUM_CLASSES edges after the final accept.
REQ-020 SHALL select the lowest-index class among equal maxima; out_tie=1 iff some other class count equals out_count.
REQ-021 SHALL select class 0 with count 0 and out_tie=1 for an all-zero window (NUM_CLASSES>1).
REQ-022 SHALL hold out_class, out_count and out_tie stable while out_valid && !out_ready, and ignore in_valid while in SCAN or RESULT.
REQ-023 SHALL, on an edge with out_valid && out_ready, zero all class counters and the sample counter and return to ACCUM, so in_ready=1 in the next cycle.
REQ-024 SHALL, on clear=1 in any state, zero all counters, drop out_valid and enter ACCUM; clear overrides a simultaneous accept (sample dropped) and a simultaneous output handshake.

Reset
REQ-025 SHALL, while reset is high, force state=ACCUM, all counters=0, out_valid=0, out_class=0, out_count=0 and out_tie=0, independent of clk.
REQ-026 SHALL discard any partial window or pending decision on reset, including a reset asserted mid-SCAN or mid-RESULT.

Structure
REQ-027 SHALL place NUM_CLASSES, CNT_W and the state encoding in the shared package bnn_pkg.
REQ-028 SHALL instantiate one sub-module, bnn_sat_counter (CNT_W-bit counter with inc, clr and saturation), per class.

Verification
REQ-029 SHALL cover WINDOW=4 with votes 0001, 0011, 0111, 0001 -> class0 count 4, class1 count 2, class2 count 1 -> out_class=0, out_count=4, out_tie=0, out_valid rising 4 edges after the last accept.
REQ-030 SHALL cover WINDOW=4 with votes 0110 x4 -> out_class=1, out_count=4, out_tie=1.
REQ-031 SHALL cover CNT_W=3, WINDOW=7 with vote 1000 x7 after clear then 1000 x10 across windows, plus a saturation case (CNT_W=3, WINDOW=7 preloaded via back-to-back 1111) -> out_count never exceeds 7, no wrap to 0.
REQ-032 SHALL cover out_ready held low 5 cycles in RESULT while in_valid=1 -> outputs constant, in_ready=0, no counts change; out_ready=1 -> next cycle in_ready=1 with counters zero.
REQ-033 SHALL cover clear asserted coincident with the 3rd accept of a WINDOW=4 window -> sample dropped, a fresh 4-sample window is required before out_valid.
REQ-034 SHALL cover reset pulsed during SCAN -> out_valid stays 0 and in_ready=1 immediately after reset deasserts.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared defaults and state encoding for the BNN class-vote accumulator.
package bnn_pkg;

    localparam int unsigned NUM_CLASSES = 4;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/bnn_sat_counter.sv
// Per-class vote counter: synchronous clear, increment, saturates at all-ones.
module bnn_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Accumulates layer-2 class votes over a window, then scans the counters one
// class per cycle and presents the arg-max class with a tie flag.
module bnn_vote_accumulator #(
    parameter  int unsigned NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter  int unsigned CNT_W       = bnn_pkg::CNT_W,
    parameter  int unsigned WINDOW      = 16,
    localparam int unsigned CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] in_votes,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_class,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_tie
);

    import bnn_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_accept;
    logic             handshake;
    logic             scan_last;
    logic             cnt_clr;
    logic [CNT_W-1:0] counts [NUM_CLASSES];
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [CLS_W-1:0] scan_idx;

    assign accept      = in_valid && (state == ST_ACCUM) && !clear;
    assign handshake   = out_valid && out_ready;
    assign last_accept = accept && (sample_cnt == CNT_W'(WINDOW - 1));
    assign scan_last   = (scan_idx == CLS_W'(NUM_CLASSES - 1));
    assign cnt_clr     = clear || handshake;
    assign cur_cnt     = counts[scan_idx];

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
        bnn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && in_votes[k]),
            .clr   (cnt_clr),
            .count (counts[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear wins over any accept or output handshake on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:  if (last_accept) state_nxt = ST_SCAN;
            ST_SCAN:   if (scan_last)   state_nxt = ST_RESULT;
            ST_RESULT: if (out_ready)   state_nxt = ST_ACCUM;
            default:                    state_nxt = ST_ACCUM;
        endcase
        if (clear) begin
            state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ST_ACCUM);
            out_valid <= (state_nxt == ST_RESULT);
        end
    end

    // Running arg-max: first class seeds it, strictly greater replaces, equal flags a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            scan_idx   <= '0;
            out_class  <= '0;
            out_count  <= '0;
            out_tie    <= 1'b0;
        end else begin
            if (cnt_clr) begin
                sample_cnt <= '0;
            end else if (accept) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if ((state == ST_SCAN) && !clear) begin
                scan_idx <= scan_idx + CLS_W'(1);
                if ((scan_idx == '0) || (cur_cnt > out_count)) begin
                    out_class <= scan_idx;
                    out_count <= cur_cnt;
                    out_tie   <= 1'b0;
                end else if (cur_cnt == out_count) begin
                    out_tie <= 1'b1;
                end
            end else begin
                scan_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Scoreboard bench: two instances (CNT_W=8/WINDOW=4 and CNT_W=3/WINDOW=7) behind one shared driver.
module tb_bnn_vote_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       iv, clr, ordy;
    logic [3:0] votes;

    logic       in_ready_a, out_valid_a, out_tie_a;
    logic [1:0] out_class_a;
    logic [7:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_tie_b;
    logic [1:0] out_class_b;
    logic [2:0] out_count_b;

    logic       rdy, ov, otie;
    logic [1:0] ocls;
    logic [7:0] ocnt;

    typedef struct {
        int cls;
        int cnt;
        int tie;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] window_q[$];
    int         win, cmax;
    int         checks, errors;

    always #5 clk = ~clk;

    bnn_vote_accumulator #(.NUM_CLASSES(4), .CNT_W(8), .WINDOW(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(iv && !sel), .in_ready(in_ready_a),
        .in_votes(votes), .clear(clr && !sel), .out_valid(out_valid_a),
        .out_ready(ordy && !sel), .out_class(out_class_a), .out_count(out_count_a),
        .out_tie(out_tie_a)
    );

    bnn_vote_accumulator #(.NUM_CLASSES(4), .CNT_W(3), .WINDOW(7)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv && sel), .in_ready(in_ready_b),
        .in_votes(votes), .clear(clr && sel), .out_valid(out_valid_b),
        .out_ready(ordy && sel), .out_class(out_class_b), .out_count(out_count_b),
        .out_tie(out_tie_b)
    );

    assign rdy  = sel ? in_ready_b  : in_ready_a;
    assign ov   = sel ? out_valid_b : out_valid_a;
    assign ocls = sel ? out_class_b : out_class_a;
    assign ocnt = sel ? {5'd0, out_count_b} : out_count_a;
    assign otie = sel ? out_tie_b : out_tie_a;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count votes per class over the window, clip, pick arg-max.
    function automatic void model_accept(input logic [3:0] v);
        int   c[4];
        int   best;
        exp_t e;
        window_q.push_back(v);
        if (window_q.size() == win) begin
            for (int k = 0; k < 4; k++) c[k] = 0;
            foreach (window_q[i]) for (int k = 0; k < 4; k++) if (window_q[i][k]) c[k]++;
            for (int k = 0; k < 4; k++) if (c[k] > cmax) c[k] = cmax;
            best = 0;
            for (int k = 1; k < 4; k++) if (c[k] > c[best]) best = k;
            e.cls = best;
            e.cnt = c[best];
            e.tie = 0;
            for (int k = 0; k < 4; k++) if (k != best && c[k] == c[best]) e.tie = 1;
            exp_q.push_back(e);
            window_q.delete();
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        int n = 0;
        iv    = 1'b1;
        votes = v;
        while (!rdy && n < 200) begin
            if (n == 3) ordy = 1'b1;
            tick();
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
        end else begin
            tick();
            model_accept(v);
        end
        iv = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic pulse_clear;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        window_q.delete();
    endtask

    task automatic use_dut(input logic s);
        sel  = s;
        win  = s ? 7 : 4;
        cmax = s ? 7 : 255;
    endtask

    initial begin
        exp_t e;
        int   n;
        checks = 0;
        errors = 0;
        iv = 1'b0; clr = 1'b0; ordy = 1'b1; votes = '0; reset = 1'b0;
        use_dut(1'b0);

        fork
            forever begin
                @(negedge clk);
                if (ov && ordy && !clr && !reset) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_decision: class %0d count %0d tie %0d", ocls, ocnt, otie);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_class", ocls, e.cls);
                        check("out_count", ocnt, e.cnt);
                        check("out_tie", otie, e.tie);
                    end
                end
            end
        join_none

        // Reset values, checked while reset is still high
        #1 reset = 1'b1;
        #17;
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_out_class_a", out_class_a, 0);
        check("rst_out_count_a", out_count_a, 0);
        check("rst_out_tie_a", out_tie_a, 0);
        check("rst_out_valid_b", out_valid_b, 0);
        check("rst_in_ready_b", in_ready_b, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Plain window with decision latency of NUM_CLASSES edges
        send(4'b0001); send(4'b0011); send(4'b0111); send(4'b0001);
        check("latency_edge0", ov, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("latency_edge%0d", i), ov, (i == 4) ? 1 : 0);
        end
        drain();

        repeat (4) send(4'b0110);
        drain();
        repeat (4) send(4'b0000);
        drain();

        // Consumer stalls five cycles while a producer keeps offering samples
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) send(4'($urandom));
        n = 0;
        while (!ov && n < 20) begin
            tick();
            n++;
        end
        check("stall_out_valid", ov, 1);
        e = exp_q[0];
        iv = 1'b1;
        votes = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_in_ready", rdy, 0);
            check("stall_valid", ov, 1);
            check("stall_class", ocls, e.cls);
            check("stall_count", ocnt, e.cnt);
            check("stall_tie", otie, e.tie);
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        check("post_handshake_in_ready", rdy, 1);
        check("post_handshake_valid", ov, 0);
        repeat (4) send(4'b0100);
        drain();

        // Clear coincident with the third accept
        send(4'b0001); send(4'b0010);
        iv = 1'b1;
        votes = 4'b1111;
        pulse_clear();
        iv = 1'b0;
        for (int i = 0; i < 3; i++) send(4'($urandom));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("clear_no_early_valid", ov, 0);
        end
        send(4'($urandom));
        drain();

        // Reset in the middle of the scan
        repeat (4) send(4'b1010);
        tick();
        #2 reset = 1'b1;
        exp_q.delete();
        window_q.delete();
        #3;
        check("scan_rst_valid", ov, 0);
        check("scan_rst_in_ready", rdy, 1);
        reset = 1'b0;
        #1;
        check("scan_rst_release_in_ready", rdy, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("scan_rst_no_valid", ov, 0);
        end

        // Narrow counters: full-window votes reach the ceiling without wrapping
        use_dut(1'b1);
        pulse_clear();
        repeat (7) send(4'b1000);
        drain();
        repeat (10) send(4'b1000);
        repeat (4) send(4'b0001);
        drain();
        repeat (7) send(4'b1111);
        drain();

        // Randomized traffic with gaps and consumer back-pressure
        use_dut(1'b0);
        pulse_clear();
        for (int i = 0; i < 80; i++) begin
            ordy = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 2)) tick();
            send(4'($urandom));
        end
        ordy = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
